// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART receive definitions: bit-timer default and RX state encodings.
package uart_rx_ctrl_pkg;

    localparam logic [13:0] BIT_TMR_MAX_DEF = 14'd10416;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with a byte holding register, VALID/ACK handshake and error pulses.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter logic [13:0] BIT_TMR_MAX = BIT_TMR_MAX_DEF,
    parameter logic [13:0] HALF_TMR    = BIT_TMR_MAX >> 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       UART_RX,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       ACK,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    logic        rx_s;
    rx_state_e   state_q, state_d;
    logic [13:0] tmr_q, tmr_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    uart_rx_sync u_sync (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .d_i    (UART_RX),
        .q_o    (rx_s)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 14'd1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = valid_q & ~ACK;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (tmr_q == HALF_TMR) begin
                    tmr_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tmr_q == BIT_TMR_MAX) begin
                    tmr_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tmr_q == BIT_TMR_MAX) begin
                    tmr_d = '0;
                    if (rx_s) begin
                        // A same-cycle ACK frees the holding register for the new byte
                        if (!valid_q || ACK) begin
                            data_d  = sh_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                tmr_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                tmr_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign DATA      = data_q;
    assign VALID     = valid_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;
    assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl at 16 cycles per bit.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] data;
    logic       valid, ferr, ovr, busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         kind;
        logic [7:0] b;
    } ev_t;
    ev_t exp_q[$];

    bit         m_full = 1'b0;
    logic [7:0] m_held = 8'h00;

    logic       pv = 1'b0;
    logic [7:0] pd = 8'h00;

    uart_rx_ctrl #(
        .BIT_TMR_MAX (14'd15),
        .HALF_TMR    (14'd7)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .UART_RX   (rx),
        .DATA      (data),
        .VALID     (valid),
        .ACK       (ack),
        .FRAME_ERR (ferr),
        .OVERRUN   (ovr),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic take(input int k, input logic [7:0] b);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL evt: unexpected kind=%0d data=%02h", k, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == 0 && e.b != b)) begin
                failures++;
                $display("FAIL evt: got kind=%0d data=%02h want kind=%0d data=%02h",
                         k, b, e.kind, e.b);
            end
        end
    endtask

    // Monitor: kind 0 = byte delivered, 1 = frame error, 2 = overrun
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                pd = 8'h00;
            end else begin
                if (ferr) take(1, 8'h00);
                if (ovr) take(2, 8'h00);
                if (valid && (!pv || data != pd)) take(0, data);
                pv = valid;
                pd = data;
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        bit was_full;
        was_full = m_full;
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        m_full = 1'b0;
        if (was_full) chk("ack_clr", valid, 0);
    endtask

    // Drives one frame starting just after a rising edge; ack_cmpl raises
    // ACK in the stop-sample cycle, rst_at >= 0 pulses reset at that cycle.
    task automatic drive_frame(input logic [7:0] b, input bit stop,
                               input bit ack_cmpl, input int rst_at);
        if (rst_at < 0) begin
            if (!stop) begin
                exp_q.push_back('{1, 8'h00});
            end else if (!m_full || ack_cmpl) begin
                exp_q.push_back('{0, b});
                m_full = 1'b1;
                m_held = b;
            end else begin
                exp_q.push_back('{2, 8'h00});
            end
        end
        for (int c = 0; c < 160; c++) begin
            if (c < 16) rx = 1'b0;
            else if (c < 144) rx = b[(c / 16) - 1];
            else rx = stop;
            ack = ack_cmpl && (c == 154);
            if (rst_at >= 0 && c == rst_at) rst_n = 1'b0;
            if (rst_at >= 0 && c == rst_at + 3) rst_n = 1'b1;
            if (rst_at >= 0 && c == rst_at + 1) begin
                chk("rst_data", data, 0);
                chk("rst_valid", valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_ferr", ferr, 0);
                chk("rst_ovr", ovr, 0);
                m_full = 1'b0;
                m_held = 8'h00;
            end
            @(posedge clk);
            #1;
        end
        ack = 1'b0;
    endtask

    task automatic drained(input string name);
        idle(5);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int cnt;
        logic [7:0] b;
        int mode;
        bit stop;

        idle(3);
        chk("reset_data", data, 0);
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ferr", ferr, 0);
        chk("reset_ovr", ovr, 0);
        rst_n = 1'b1;
        idle(3);

        drive_frame(8'h55, 1'b1, 1'b0, -1);
        rx = 1'b1;
        drained("f55_drain");
        chk("f55_valid", valid, 1);
        chk("f55_data", data, 8'h55);
        ack_pulse();
        idle(3);

        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            rx = (c < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (busy) cnt++;
            @(posedge clk);
            #1;
        end
        chk("glitch_busy_cycles", cnt, 8);
        chk("glitch_valid", valid, 0);
        drained("glitch_drain");

        drive_frame(8'hA3, 1'b0, 1'b0, -1);
        idle(20);
        chk("ferr_busy_low", busy, 1);
        chk("ferr_valid", valid, 0);
        rx = 1'b1;
        idle(5);
        chk("ferr_busy_rel", busy, 0);
        drained("ferr_drain");

        drive_frame(8'h12, 1'b1, 1'b0, -1);
        drive_frame(8'h34, 1'b1, 1'b0, -1);
        rx = 1'b1;
        drained("ovr_drain");
        chk("ovr_data", data, 8'h12);
        chk("ovr_valid", valid, 1);
        ack_pulse();
        idle(3);

        drive_frame(8'h12, 1'b1, 1'b0, -1);
        drive_frame(8'h34, 1'b1, 1'b1, -1);
        rx = 1'b1;
        drained("ackc_drain");
        chk("ackc_data", data, 8'h34);
        chk("ackc_valid", valid, 1);
        ack_pulse();
        idle(3);

        drive_frame(8'hFF, 1'b1, 1'b0, 88);
        rx = 1'b1;
        idle(3);
        drive_frame(8'h0F, 1'b1, 1'b0, -1);
        rx = 1'b1;
        drained("post_rst_drain");
        chk("post_rst_data", data, 8'h0F);
        ack_pulse();
        idle(3);

        for (int n = 0; n < 14; n++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            mode = $urandom_range(0, 2);
            if (mode == 1) ack_pulse();
            if (mode == 2 && m_full && b == m_held) b = b ^ 8'h01;
            drive_frame(b, stop, mode == 2, -1);
            if (!stop) idle($urandom_range(0, 20));
            rx = 1'b1;
            idle($urandom_range(4, 12));
            chk("rand_valid", valid, int'(m_full));
            if (m_full) chk("rand_data", data, m_held);
        end
        drained("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
